sort_frontend: RTL and testbench
================================

Name: sort_frontend

Overview:
- Front-end stage wrapped around the selection-sort datapath and controller; owns the shared 8-entry value memory whenever the sorter is not running.
- Fills memory from a valid/ready input stream, then pulses the sorter start for one cycle and waits for sort done.
- Drains the sorted contents as a valid/ready output stream, re-arms the sorter, and returns to filling.

Parameters:
- DATA_W, 8, width of each stored value
- DEPTH, 8, number of entries (power of two)
- ADDR_W, 3, log2(DEPTH)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous abort, highest priority after reset
- in_valid  in  1  input value offered
- in_ready  out  1  block accepts a value this cycle
- in_data  in  DATA_W  input value
- out_valid  out  1  sorted value presented
- out_ready  in  1  consumer accepts the value
- out_data  out  DATA_W  sorted value
- out_last  out  1  marks entry DEPTH-1 on the output stream
- mem_own  out  1  1 = this block drives the memory port; 0 = sorter drives it
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  write/read address
- mem_wdata  out  DATA_W  write data
- mem_rd  out  1  read strobe; mem_rdata is valid the following cycle
- mem_rdata  in  DATA_W  read data
- sort_start  out  1  one-cycle start pulse to the sorter
- sort_done  in  1  sorter finished; level, held until the sorter is re-armed
- sort_clr  out  1  one-cycle pulse that returns the sorter to idle
- fill_count  out  ADDR_W+1  number of entries written in the current fill

Behaviour:
- States: FILL, START, WAIT_SORT, FETCH, LATCH, PRESENT, REARM.
- Reset:
  - State becomes FILL; wr_ptr, rd_ptr and fill_count = 0.
  - out_valid, out_data, out_last, mem_we, mem_rd, sort_start and sort_clr = 0; mem_own = 1.
  - in_ready = 1 from the first cycle after reset deasserts.
- FILL:
  - in_ready = 1, mem_own = 1.
  - On in_valid && in_ready, combinationally drive mem_we = 1, mem_addr = wr_ptr, mem_wdata = in_data; wr_ptr and fill_count increment at the clock edge.
  - Accepting entry DEPTH-1 moves to START, and wr_ptr wraps to 0.
  - With in_valid low, no write occurs and the state holds.
- START: sort_start = 1 for exactly one cycle; mem_own = 0; in_ready = 0; go to WAIT_SORT.
- WAIT_SORT:
  - mem_own = 0; all memory strobes 0.
  - When sort_done = 1, set rd_ptr = 0 and go to FETCH. sort_done is ignored in every other state.
- FETCH: mem_own = 1, mem_rd = 1, mem_addr = rd_ptr; go to LATCH.
- LATCH: out_data <= mem_rdata and out_last <= (rd_ptr == DEPTH-1) at the clock edge; go to PRESENT.
- PRESENT:
  - out_valid = 1. out_data and out_last stay stable while out_ready = 0.
  - On out_ready: if rd_ptr == DEPTH-1, go to REARM; otherwise increment rd_ptr and go to FETCH.
  - Throughput is one value per 3 cycles with out_ready held high. Latency from sort_done to the first out_valid is 3 cycles.
- REARM: sort_clr = 1 for one cycle; mem_own = 1; fill_count <= 0; go to FILL.
- clear (synchronous):
  - Any state except FILL: go to REARM; out_valid drops next cycle; pointers are zeroed.
  - In FILL: stay in FILL; pointers and fill_count are zeroed; no sort_clr pulse.
  - A write offered in the same cycle as clear is dropped: in_ready = 0 while clear = 1.
- Asynchronous reset mid-sort or mid-drain: immediate return to the reset values above. The sorter is reset by the same line.
- Arithmetic:
  - Pointers are ADDR_W bits and wrap naturally.
  - fill_count saturates at DEPTH; it never exceeds DEPTH because FILL exits on the DEPTH-th accept.

Decomposition:
- Shared package sort_pkg holds:
  - DATA_W, DEPTH and ADDR_W defaults;
  - the frontend_state_t enum;
  - the sorter_state_t enum used by the sorter, so both FSMs are visible to the bench.
- No sub-module: a single FSM with the pointer and output registers. The memory address/data mux selected by mem_own lives at the top level.

Test Plan:
- Reset: hold reset 3 cycles, then release -> all outputs at reset values, mem_own = 1, in_ready = 1, fill_count = 0.
- Fill: stream 5,3,7,1,0,6,2,4 with in_valid constant -> mem_we on 8 consecutive cycles at addr 0..7; in_ready = 0 after the 8th accept; sort_start high exactly one cycle; mem_own = 0.
- Gapped fill: in_valid toggles 1,0,1,0 -> writes only on valid cycles; fill_count steps 0..8; no write on idle cycles.
- Drain with backpressure: model memory returns 0..7; sort_done asserted 20 cycles after start; out_ready low for 4 cycles on entry 2 -> values 0..7 in order; out_data held stable during the stall; out_last only with 7; sort_clr pulse follows; in_ready = 1 again.
- clear during WAIT_SORT -> one sort_clr pulse, no output values, fill_count = 0, FILL accepts a new 8-value set correctly.
- Async reset asserted while in PRESENT at entry 4 -> out_valid drops immediately; after release, FILL starts and writes begin at addr 0.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the selection-sort slice: default geometry and the
// state encodings of both the front-end and the sorter controller.
package sort_pkg;

   localparam int SORT_DATA_W = 8;
   localparam int SORT_DEPTH  = 8;
   localparam int SORT_ADDR_W = 3;

   typedef enum logic [2:0] {
      FILL,
      START,
      WAIT_SORT,
      FETCH,
      LATCH,
      PRESENT,
      REARM
   } frontend_state_t;

   typedef enum logic [2:0] {
      SORT_IDLE,
      SORT_OUTER,
      SORT_SCAN,
      SORT_SWAP_RD,
      SORT_SWAP_WR,
      SORT_DONE
   } sorter_state_t;

endpackage

// File: rtl/sort_frontend.sv
// Front-end of the selection sorter: fills the shared value memory from an
// input stream, hands it to the sorter, then drains the sorted result.
module sort_frontend
   import sort_pkg::*;
#(
   parameter int DATA_W = SORT_DATA_W,
   parameter int DEPTH  = SORT_DEPTH,
   parameter int ADDR_W = SORT_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              mem_own,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              sort_start,
   input  logic              sort_done,
   output logic              sort_clr,
   output logic [ADDR_W:0]   fill_count
);

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   frontend_state_t r_state;
   frontend_state_t w_nextState;

   logic [ADDR_W-1:0] r_wrPtr;
   logic [ADDR_W-1:0] r_rdPtr;
   logic [ADDR_W:0]   r_fillCount;
   logic [DATA_W-1:0] r_outData;
   logic              r_outLast;

   logic w_accept;
   logic w_lastWrite;
   logic w_lastRead;

   // A write offered alongside clear is refused rather than silently lost.
   assign in_ready    = (r_state == FILL) && !clear && !reset;
   assign w_accept    = in_valid && in_ready;
   assign w_lastWrite = (r_wrPtr == LAST_ADDR);
   assign w_lastRead  = (r_rdPtr == LAST_ADDR);

   assign out_valid  = (r_state == PRESENT);
   assign out_data   = r_outData;
   assign out_last   = r_outLast;
   assign sort_start = (r_state == START);
   assign sort_clr   = (r_state == REARM);
   assign fill_count = r_fillCount;

   // The sorter owns the memory only between the start pulse and sort_done.
   assign mem_own   = (r_state != START) && (r_state != WAIT_SORT);
   assign mem_we    = w_accept;
   assign mem_rd    = (r_state == FETCH);
   assign mem_addr  = !mem_own ? '0 : ((r_state == FETCH) ? r_rdPtr : r_wrPtr);
   assign mem_wdata = mem_own ? in_data : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= FILL;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      if (clear) begin
         w_nextState = (r_state == FILL) ? FILL : REARM;
      end else begin
         case (r_state)
            FILL:      if (w_accept && w_lastWrite) w_nextState = START;
            START:     w_nextState = WAIT_SORT;
            WAIT_SORT: if (sort_done) w_nextState = FETCH;
            FETCH:     w_nextState = LATCH;
            LATCH:     w_nextState = PRESENT;
            PRESENT:   if (out_ready) w_nextState = w_lastRead ? REARM : FETCH;
            REARM:     w_nextState = FILL;
            default:   w_nextState = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_fillCount <= '0;
         r_outData   <= '0;
         r_outLast   <= 1'b0;
      end else if (clear) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_fillCount <= '0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_accept) begin
                  r_wrPtr <= r_wrPtr + 1'b1;
                  if (r_fillCount != FULL_COUNT) r_fillCount <= r_fillCount + 1'b1;
               end
            end
            WAIT_SORT: if (sort_done) r_rdPtr <= '0;
            LATCH: begin
               r_outData <= mem_rdata;
               r_outLast <= w_lastRead;
            end
            PRESENT: if (out_ready && !w_lastRead) r_rdPtr <= r_rdPtr + 1'b1;
            REARM:   r_fillCount <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sort_frontend.sv
// Scoreboard bench for sort_frontend: a behavioural memory/sorter model drives
// the memory port, and every fill pushes the sorted set as expected output.
module tb_sort_frontend;

   localparam int SORT_DELAY = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_last;
   logic       mem_own;
   logic       mem_we;
   logic [2:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_rd;
   logic [7:0] mem_rdata;
   logic       sort_start;
   logic       sort_done;
   logic       sort_clr;
   logic [3:0] fill_count;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t       expQ[$];
   exp_t       expItem;
   int         errors = 0;
   int         checks = 0;
   int         popIdx = 0;
   int         stallIdx = -1;
   int         stallLeft = 0;
   bit         randStall = 0;
   bit         prevStalled = 0;
   logic [7:0] prevData;
   logic       prevLast;

   logic [7:0] mem [8];
   logic [7:0] sortQ[$];
   int         sortCnt;
   bit         sortBusy;

   sort_frontend dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .mem_own    (mem_own),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rd     (mem_rd),
      .mem_rdata  (mem_rdata),
      .sort_start (sort_start),
      .sort_done  (sort_done),
      .sort_clr   (sort_clr),
      .fill_count (fill_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Memory with one-cycle read latency plus a sorter that sorts the array in place.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sort_done <= 1'b0;
         sortBusy  <= 1'b0;
         sortCnt   <= 0;
         mem_rdata <= 8'd0;
      end else begin
         if (mem_we && mem_own) mem[mem_addr] <= mem_wdata;
         if (mem_rd && mem_own) mem_rdata <= mem[mem_addr];
         if (sort_clr) begin
            sort_done <= 1'b0;
            sortBusy  <= 1'b0;
         end else if (sort_start) begin
            sortBusy <= 1'b1;
            sortCnt  <= SORT_DELAY;
         end else if (sortBusy) begin
            if (sortCnt == 1) begin
               sortQ.delete();
               for (int i = 0; i < 8; i++) sortQ.push_back(mem[i]);
               sortQ.sort();
               for (int i = 0; i < 8; i++) mem[i] <= sortQ[i];
               sort_done <= 1'b1;
               sortBusy  <= 1'b0;
            end else begin
               sortCnt <= sortCnt - 1;
            end
         end
      end
   end

   // Monitor: drives backpressure and pops the scoreboard on each handshake.
   always @(negedge clk) begin
      if (reset) begin
         prevStalled = 0;
         out_ready   = 1'b1;
      end else if (out_valid) begin
         if (prevStalled) begin
            checkOutput("stall_data_hold", 32'(out_data), 32'(prevData));
            checkOutput("stall_last_hold", 32'(out_last), 32'(prevLast));
         end
         if ((popIdx == stallIdx && stallLeft > 0) || (randStall && $urandom_range(0, 3) == 0)) begin
            if (popIdx == stallIdx && stallLeft > 0) stallLeft--;
            out_ready   = 1'b0;
            prevStalled = 1;
            prevData    = out_data;
            prevLast    = out_last;
         end else begin
            out_ready   = 1'b1;
            prevStalled = 0;
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output: got %0d, expected no output", out_data);
            end else begin
               expItem = expQ.pop_front();
               checkOutput("out_data", 32'(out_data), 32'(expItem.data));
               checkOutput("out_last", 32'(out_last), 32'(expItem.last));
            end
            popIdx++;
         end
      end else begin
         out_ready   = 1'b1;
         prevStalled = 0;
      end
   end

   task automatic flushScoreboard();
      expQ.delete();
      popIdx    = 0;
      stallIdx  = -1;
      stallLeft = 0;
      randStall = 0;
   endtask

   task automatic applyReset(input int cycles);
      reset    = 1'b1;
      clear    = 1'b0;
      in_valid = 1'b0;
      repeat (cycles) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Fills one set starting in FILL at posedge+1; returns in WAIT_SORT at posedge+1.
   task automatic applyStimulus(input logic [7:0] vals [8], input bit gapped);
      logic [7:0] setQ[$];
      for (int i = 0; i < 8; i++) begin
         if (gapped && i > 0) begin
            in_valid = 1'b0;
            @(negedge clk);
            checkOutput("idle_no_write", 32'(mem_we), 0);
            checkOutput("idle_fill_count", 32'(fill_count), i);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = vals[i];
         @(negedge clk);
         checkOutput("fill_in_ready", 32'(in_ready), 1);
         checkOutput("fill_we", 32'(mem_we), 1);
         checkOutput("fill_addr", 32'(mem_addr), i);
         checkOutput("fill_wdata", 32'(mem_wdata), 32'(vals[i]));
         @(posedge clk); #1;
         checkOutput("fill_count", 32'(fill_count), i + 1);
         setQ.push_back(vals[i]);
      end
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("start_pulse", 32'(sort_start), 1);
      checkOutput("start_in_ready", 32'(in_ready), 0);
      checkOutput("start_mem_own", 32'(mem_own), 0);
      @(negedge clk);
      checkOutput("start_single", 32'(sort_start), 0);
      checkOutput("wait_mem_own", 32'(mem_own), 0);
      checkOutput("wait_no_write", 32'(mem_we), 0);
      setQ.sort();
      for (int i = 0; i < 8; i++) expQ.push_back('{data: setQ[i], last: (i == 7)});
      @(posedge clk); #1;
   endtask

   task automatic checkLatency();
      int g = 0;
      int n = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!sort_done && g < 200);
      checkOutput("sort_done_seen", 32'(sort_done), 1);
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      checkOutput("done_to_valid_latency", n, 3);
   endtask

   task automatic drainAndRearm();
      int g = 0;
      while (expQ.size() != 0 && g < 500) begin
         @(posedge clk);
         g++;
      end
      checkOutput("drain_complete", expQ.size(), 0);
      #1;
      @(negedge clk);
      checkOutput("rearm_sort_clr", 32'(sort_clr), 1);
      checkOutput("rearm_out_valid", 32'(out_valid), 0);
      checkOutput("rearm_mem_own", 32'(mem_own), 1);
      @(negedge clk);
      checkOutput("refill_in_ready", 32'(in_ready), 1);
      checkOutput("refill_count", 32'(fill_count), 0);
      checkOutput("clr_single", 32'(sort_clr), 0);
      @(posedge clk); #1;
   endtask

   task automatic randomSet(output logic [7:0] vals [8]);
      for (int i = 0; i < 8; i++) vals[i] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      logic [7:0] v [8];
      int g;

      applyReset(3);
      @(negedge clk);
      checkOutput("reset_in_ready", 32'(in_ready), 1);
      checkOutput("reset_mem_own", 32'(mem_own), 1);
      checkOutput("reset_fill_count", 32'(fill_count), 0);
      checkOutput("reset_out_valid", 32'(out_valid), 0);
      checkOutput("reset_out_data", 32'(out_data), 0);
      checkOutput("reset_out_last", 32'(out_last), 0);
      checkOutput("reset_sort_start", 32'(sort_start), 0);
      checkOutput("reset_sort_clr", 32'(sort_clr), 0);
      checkOutput("reset_mem_rd", 32'(mem_rd), 0);
      @(posedge clk); #1;

      // Directed set with a four-cycle stall on entry 2.
      flushScoreboard();
      v = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
      stallIdx  = 2;
      stallLeft = 4;
      applyStimulus(v, 1'b0);
      checkLatency();
      drainAndRearm();

      // Gapped fill with random backpressure.
      flushScoreboard();
      randStall = 1;
      randomSet(v);
      applyStimulus(v, 1'b1);
      drainAndRearm();

      // Clear in the middle of a fill.
      flushScoreboard();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom_range(0, 255));
         @(posedge clk); #1;
      end
      checkOutput("pre_clear_count", 32'(fill_count), 3);
      clear = 1'b1;
      @(negedge clk);
      checkOutput("clear_in_ready", 32'(in_ready), 0);
      checkOutput("clear_drops_write", 32'(mem_we), 0);
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      checkOutput("fill_clear_count", 32'(fill_count), 0);
      checkOutput("fill_clear_no_clr", 32'(sort_clr), 0);
      randomSet(v);
      applyStimulus(v, 1'b0);
      drainAndRearm();

      // Clear while waiting for the sorter.
      randomSet(v);
      applyStimulus(v, 1'b0);
      flushScoreboard();
      repeat (3) @(posedge clk);
      #1 clear = 1'b1;
      @(negedge clk);
      checkOutput("wait_clear_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      clear = 1'b0;
      @(negedge clk);
      checkOutput("wait_clear_sort_clr", 32'(sort_clr), 1);
      checkOutput("wait_clear_out_valid", 32'(out_valid), 0);
      checkOutput("wait_clear_count", 32'(fill_count), 0);
      @(negedge clk);
      checkOutput("wait_clear_clr_single", 32'(sort_clr), 0);
      checkOutput("wait_clear_in_ready_back", 32'(in_ready), 1);
      @(posedge clk); #1;
      randStall = 1;
      randomSet(v);
      applyStimulus(v, 1'b0);
      drainAndRearm();

      // Asynchronous reset while entry 4 is presented.
      flushScoreboard();
      randomSet(v);
      applyStimulus(v, 1'b0);
      stallIdx  = 4;
      stallLeft = 20;
      g = 0;
      while (!(out_valid && popIdx == 4) && g < 300) begin
         @(posedge clk); #1;
         g++;
      end
      checkOutput("reached_entry4", popIdx, 4);
      #1 reset = 1'b1;
      #1;
      checkOutput("async_out_valid", 32'(out_valid), 0);
      checkOutput("async_mem_own", 32'(mem_own), 1);
      checkOutput("async_out_data", 32'(out_data), 0);
      checkOutput("async_fill_count", 32'(fill_count), 0);
      flushScoreboard();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      randomSet(v);
      applyStimulus(v, 1'b0);
      drainAndRearm();

      // A few more random sets under random backpressure.
      for (int s = 0; s < 3; s++) begin
         flushScoreboard();
         randStall = 1;
         randomSet(v);
         applyStimulus(v, (s % 2) == 1);
         drainAndRearm();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
